// File: rtl/mac_acc_nx8.sv
// mac_acc_nx8: LANES-wide signed dot-product accumulated over packets of beats.
// Three-stage pipeline (products, beat sum, accumulate) with a held result register.
module mac_acc_nx8 #(
    parameter int DATA_WIDTH = 8,
    parameter int LANES      = 4,
    parameter int ACC_WIDTH  = 32,
    parameter int SATURATE   = 0
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [LANES*DATA_WIDTH-1:0] a_flat,
    input  logic [LANES*DATA_WIDTH-1:0] b_flat,
    input  logic                        in_valid,
    input  logic                        in_first,
    input  logic                        in_last,
    output logic                        in_ready,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [ACC_WIDTH-1:0]        result,
    output logic                        out_ovf
);

    localparam int PROD_W = 2 * DATA_WIDTH;
    localparam int SUM_W  = PROD_W + $clog2(LANES);
    localparam logic [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
    localparam logic [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};

    logic                        stall_s;
    logic signed [PROD_W-1:0]    prod_s [LANES];
    logic signed [SUM_W-1:0]     sum_s;
    logic [ACC_WIDTH-1:0]        base_s;
    logic [ACC_WIDTH:0]          wide_sum_s;
    logic [ACC_WIDTH-1:0]        acc_next_s;
    logic                        ovf_now_s;
    logic                        sticky_next_s;

    logic                        p1_valid_r;
    logic                        p1_first_r;
    logic                        p1_last_r;
    logic signed [PROD_W-1:0]    p1_prod_r [LANES];
    logic                        p2_valid_r;
    logic                        p2_first_r;
    logic                        p2_last_r;
    logic signed [ACC_WIDTH-1:0] p2_sum_r;
    logic [ACC_WIDTH-1:0]        acc_r;
    logic                        ovf_sticky_r;
    logic [ACC_WIDTH-1:0]        result_r;
    logic                        out_ovf_r;
    logic                        out_valid_r;

    // A pending, unaccepted result freezes every stage so nothing is lost.
    assign stall_s   = out_valid_r & ~out_ready;
    assign in_ready  = ~stall_s;
    assign out_valid = out_valid_r;
    assign result    = result_r;
    assign out_ovf   = out_ovf_r;

    // Full-width signed product per lane of the incoming beat
    always_comb begin
        for (int i = 0; i < LANES; i++) begin
            prod_s[i] = PROD_W'($signed(a_flat[i*DATA_WIDTH +: DATA_WIDTH]))
                      * PROD_W'($signed(b_flat[i*DATA_WIDTH +: DATA_WIDTH]));
        end
    end

    // Exact sum of the registered lane products
    always_comb begin
        sum_s = {SUM_W{1'b0}};
        for (int i = 0; i < LANES; i++) begin
            sum_s = sum_s + SUM_W'(p1_prod_r[i]);
        end
    end

    // Accumulator add: one extra bit exposes signed overflow, then wrap or clamp
    always_comb begin
        base_s     = p2_first_r ? {ACC_WIDTH{1'b0}} : acc_r;
        wide_sum_s = {base_s[ACC_WIDTH-1], base_s} + {p2_sum_r[ACC_WIDTH-1], p2_sum_r};
        ovf_now_s  = wide_sum_s[ACC_WIDTH] ^ wide_sum_s[ACC_WIDTH-1];
        if (ovf_now_s && (SATURATE != 32'sd0)) begin
            acc_next_s = wide_sum_s[ACC_WIDTH] ? ACC_MIN : ACC_MAX;
        end else begin
            acc_next_s = wide_sum_s[ACC_WIDTH-1:0];
        end
        sticky_next_s = (p2_first_r ? 1'b0 : ovf_sticky_r) | ovf_now_s;
    end

    // Stage 1: capture beat control and lane products
    always_ff @(posedge clk) begin
        if (rst) begin
            p1_valid_r <= 1'b0;
            p1_first_r <= 1'b0;
            p1_last_r  <= 1'b0;
            for (int i = 0; i < LANES; i++) begin
                p1_prod_r[i] <= {PROD_W{1'b0}};
            end
        end else if (!stall_s) begin
            p1_valid_r <= in_valid;
            p1_first_r <= in_valid & in_first;
            p1_last_r  <= in_valid & in_last;
            for (int i = 0; i < LANES; i++) begin
                p1_prod_r[i] <= prod_s[i];
            end
        end
    end

    // Stage 2: capture the sign-extended beat sum
    always_ff @(posedge clk) begin
        if (rst) begin
            p2_valid_r <= 1'b0;
            p2_first_r <= 1'b0;
            p2_last_r  <= 1'b0;
            p2_sum_r   <= {ACC_WIDTH{1'b0}};
        end else if (!stall_s) begin
            p2_valid_r <= p1_valid_r;
            p2_first_r <= p1_first_r;
            p2_last_r  <= p1_last_r;
            p2_sum_r   <= ACC_WIDTH'(sum_s);
        end
    end

    // Stage 3: accumulate; a last beat loads the result and restarts from zero
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_r        <= {ACC_WIDTH{1'b0}};
            ovf_sticky_r <= 1'b0;
            result_r     <= {ACC_WIDTH{1'b0}};
            out_ovf_r    <= 1'b0;
            out_valid_r  <= 1'b0;
        end else if (!stall_s) begin
            out_valid_r <= p2_valid_r & p2_last_r;
            if (p2_valid_r) begin
                if (p2_last_r) begin
                    result_r     <= acc_next_s;
                    out_ovf_r    <= sticky_next_s;
                    acc_r        <= {ACC_WIDTH{1'b0}};
                    ovf_sticky_r <= 1'b0;
                end else begin
                    acc_r        <= acc_next_s;
                    ovf_sticky_r <= sticky_next_s;
                end
            end
        end
    end

endmodule
